// File: rtl/mod47_pkg.sv
// Shared constants, FSM state type and input reduction for the mod-47 exponentiator.
// All stored residues are 6 bits wide and lie in 0..46.
package mod47_pkg;

  localparam int MOD   = 47;
  localparam int RES_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SQR  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A 6-bit input never reaches 2*MOD, so one conditional subtract is enough.
  function automatic logic [RES_W-1:0] reduce(input logic [RES_W-1:0] x);
    return (x >= RES_W'(MOD)) ? x - RES_W'(MOD) : x;
  endfunction

endpackage

// File: rtl/mod47_exp_seq_modmul.sv
// Combinational 6x6 modular multiplier: R = (A * B) mod 47.
// It is time-shared by the exponentiator for both the multiply and the square steps.
module ModuloMultiplication
  import mod47_pkg::*;
(
  input  logic [RES_W-1:0] A,
  input  logic [RES_W-1:0] B,
  output logic [RES_W-1:0] R
);

  logic [2*RES_W-1:0] prod;
  logic [2*RES_W-1:0] prod_mod;

  assign prod     = A * B;
  assign prod_mod = prod % (2*RES_W)'(MOD);
  assign R        = prod_mod[RES_W-1:0];

endmodule

// File: rtl/mod47_exp_seq.sv
// Sequential R = A^E mod 47 using right-to-left square-and-multiply.
// Alternates MUL and SQR cycles over one shared modular multiplier; fixed latency 2*EXP_W.
module mod47_exp_seq
  import mod47_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       A,
  input  logic [EXP_W-1:0] E,
  output logic             busy,
  output logic             done,
  output logic [5:0]       R
);

  localparam int CNT_W = $clog2(EXP_W) + 1;

  state_t             state_reg;
  state_t             state_next;
  logic [RES_W-1:0]   acc_reg;
  logic [RES_W-1:0]   b_reg;
  logic [EXP_W-1:0]   e_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [RES_W-1:0]   r_reg;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_iter;
  logic [RES_W-1:0]   mul_a;
  logic [RES_W-1:0]   mul_b;
  logic [RES_W-1:0]   mul_r;

  assign cnt_inc   = cnt_reg + 1'b1;
  assign last_iter = (cnt_inc == CNT_W'(EXP_W));

  // MUL multiplies the accumulator by the current base power; SQR squares the base.
  assign mul_a = (state_reg == SQR) ? b_reg : acc_reg;
  assign mul_b = b_reg;

  ModuloMultiplication u_modmul (
    .A (mul_a),
    .B (mul_b),
    .R (mul_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = start ? MUL : IDLE;
      MUL:     state_next = SQR;
      SQR:     state_next = last_iter ? DONE : MUL;
      DONE:    state_next = start ? MUL : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      MUL, SQR: busy = 1'b1;
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      b_reg   <= '0;
      e_reg   <= '0;
      cnt_reg <= '0;
      r_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            acc_reg <= RES_W'(1);
            b_reg   <= reduce(A);
            e_reg   <= E;
            cnt_reg <= '0;
          end
        end
        MUL: begin
          if (e_reg[0]) begin
            acc_reg <= mul_r;
          end
        end
        SQR: begin
          b_reg   <= mul_r;
          e_reg   <= e_reg >> 1;
          cnt_reg <= cnt_inc;
          // The result register only moves when a run completes.
          if (last_iter) begin
            r_reg <= acc_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign R = r_reg;

endmodule

// File: tb/tb_mod47_exp_seq.sv
// Self-checking bench for mod47_exp_seq: a timing/arithmetic model checked every cycle,
// plus directed cases with hand-computed results and randomized operands.
module tb_mod47_exp_seq;

  localparam int EXP_W = 8;
  localparam int LAT   = 2 * EXP_W;

  logic             clk;
  logic             rst;
  logic             start;
  logic [5:0]       A;
  logic [EXP_W-1:0] E;
  logic             busy;
  logic             done;
  logic [5:0]       R;

  int total;
  int bad;

  mod47_exp_seq #(.EXP_W(EXP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .E     (E),
    .busy  (busy),
    .done  (done),
    .R     (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain repeated multiplication; deliberately not square-and-multiply.
  function automatic int modexp(input int a, input int e);
    int base;
    int r;
    base = (a >= 47) ? a - 47 : a;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * base) % 47;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is a timer of LAT cycles, then one done cycle.
  bit m_running;
  int m_cnt;
  bit m_done;
  int m_r;
  int m_pending;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_running = 1'b0;
      m_cnt     = 0;
      m_done    = 1'b0;
      m_r       = 0;
    end else if (m_running) begin
      m_cnt++;
      if (m_cnt == LAT) begin
        m_running = 1'b0;
        m_done    = 1'b1;
        m_r       = m_pending;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_running = 1'b1;
        m_cnt     = 0;
        m_pending = modexp(int'(A), int'(E));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", int'(busy), int'(m_running));
      check("done", int'(done), int'(m_done));
      check("R",    int'(R),    m_r);
    end
  end

  // Issues a start from the current time; returns at the negedge where done is seen.
  task automatic run_op(input int a, input int e, input int exp_r, input bit poke_mid);
    int lat;
    int busy_cyc;
    bit seen;
    start = 1'b1;
    A = 6'(a);
    E = EXP_W'(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 6'($urandom_range(0, 63));
    E = EXP_W'($urandom_range(0, 255));
    lat = 0;
    busy_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i <= LAT + 8; i++) begin
      @(negedge clk);
      if (poke_mid && i == 5) start = 1'b1;
      if (poke_mid && i == 6) start = 1'b0;
      if (done) begin
        lat = i;
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
    end
    check("done_seen", int'(seen), 1);
    check("latency", lat, LAT);
    check("busy_cycles", busy_cyc, LAT);
    check("result", int'(R), exp_r);
    $display("op A=%0d E=%0d R=%0d expect=%0d latency=%0d", a, e, R, exp_r, lat);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int dones;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    E     = '0;

    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_R",    int'(R),    0);
    gap(2);
    rst = 1'b0;
    gap(1);

    // Pin the model against hand-computed values.
    check("model_45_15", modexp(45, 15), 38);
    check("model_2_255", modexp(2, 255), 4);
    check("model_50_4",  modexp(50, 4),  34);
    check("model_0_0",   modexp(0, 0),   1);

    run_op(45, 15, 38, 1'b0);
    gap(2);
    run_op(2, 255, 4, 1'b0);
    gap(1);
    run_op(5, 46, 1, 1'b0);
    gap(1);
    run_op(50, 4, 34, 1'b0);
    gap(1);
    run_op(0, 0, 1, 1'b0);
    gap(1);
    run_op(0, 5, 0, 1'b0);
    gap(1);
    run_op(47, 3, 0, 1'b0);
    gap(3);

    // Back-to-back: second start issued during the DONE cycle, plus an ignored mid-run start.
    run_op(45, 15, 38, 1'b0);
    run_op(2, 23, 1, 1'b1);
    gap(2);

    // Reset in the middle of a run.
    start = 1'b1;
    A = 6'd45;
    E = EXP_W'(15);
    @(posedge clk);
    #1;
    start = 1'b0;
    gap(7);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_R",    int'(R),    0);
    gap(2);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    $display("op reset-abort done_pulses=%0d R=%0d", dones, R);
    @(posedge clk);
    #1;
    run_op(3, 2, 9, 1'b0);

    // Randomized operands against the model, with occasional back-to-back starts.
    for (int n = 0; n < 40; n++) begin
      int a;
      int e;
      a = $urandom_range(0, 63);
      e = $urandom_range(0, 255);
      if ($urandom_range(0, 2) != 0) gap($urandom_range(1, 3));
      run_op(a, e, modexp(a, e), bit'($urandom_range(0, 1)));
    end
    gap(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
